// File: rtl/adder_seq.sv
// adder_seq: multi-cycle adder/subtractor, CHUNK bits per clock, LSB chunk first, with valid/ready handshakes and status flags
module adder_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] a_q, b_q, sum_nx;
    logic [CHUNK:0] part;
    logic [CW-1:0] cnt;
    logic carry, last;
    assign in_ready = state == IDLE;
    // Operands shift right each cycle so the active chunk is always the low one; results shift into the sum from the top
    always_comb begin
        part = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
        sum_nx = (sum >> CHUNK) | (WIDTH'(part[CHUNK-1:0]) << (WIDTH - CHUNK));
        last = cnt == CW'(NCHUNK - 1);
    end
    // Handshake FSM plus chunk datapath; on the final chunk the MSB carry-in is recovered as a^b^s at the MSB
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            carry <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            out_valid <= 1'b0;
            sum <= '0;
            cout <= 1'b0;
            ovf <= 1'b0;
            zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q <= a;
                    b_q <= sub ? ~b : b;
                    carry <= sub | cin;
                    cnt <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    a_q <= a_q >> CHUNK;
                    b_q <= b_q >> CHUNK;
                    sum <= sum_nx;
                    carry <= part[CHUNK];
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state <= DONE;
                        cnt <= '0;
                        cout <= part[CHUNK];
                        ovf <= a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ part[CHUNK-1] ^ part[CHUNK];
                        zero <= sum_nx == '0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_seq.sv
// tb_adder_seq: directed and sweep checks of adder_seq at 32/4, 4/1, 4/4 and 32/8
module tb_adder_seq;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic in_valid = 0, sub = 0, cin = 0, out_ready = 0;
    logic [31:0] a = 0, b = 0, sum;
    logic in_ready, out_valid, cout, ovf, zero;
    adder_seq #(.WIDTH(32), .CHUNK(4)) dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero));

    logic v4 = 0, s4 = 0, c4 = 0, r4 = 0;
    logic [3:0] a4 = 0, b4 = 0, sm41, sm44;
    logic ir41, ov41, co41, of41, z41, ir44, ov44, co44, of44, z44;
    adder_seq #(.WIDTH(4), .CHUNK(1)) dut41 (.clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir41),
        .a(a4), .b(b4), .sub(s4), .cin(c4), .out_valid(ov41), .out_ready(r4),
        .sum(sm41), .cout(co41), .ovf(of41), .zero(z41));
    adder_seq #(.WIDTH(4), .CHUNK(4)) dut44 (.clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir44),
        .a(a4), .b(b4), .sub(s4), .cin(c4), .out_valid(ov44), .out_ready(r4),
        .sum(sm44), .cout(co44), .ovf(of44), .zero(z44));

    logic v8 = 0, s8 = 0, c8 = 0, r8 = 0;
    logic [31:0] a8 = 0, b8 = 0, sm8;
    logic ir8, ov8, co8, of8, z8;
    adder_seq #(.WIDTH(32), .CHUNK(8)) dut328 (.clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8),
        .a(a8), .b(b8), .sub(s8), .cin(c8), .out_valid(ov8), .out_ready(r8),
        .sum(sm8), .cout(co8), .ovf(of8), .zero(z8));

    int checks = 0, errors = 0;

    // Reference: unsigned result for sum/cout, exact signed result for ovf
    function automatic void model(input int w, input longint x, input longint y, input bit sb, input bit ci,
                                  output longint s, output bit co, output bit ov, output bit z);
        longint m, half, sx, sy, r, e;
        m = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sx = x >= half ? x - (m + 1) : x;
        sy = y >= half ? y - (m + 1) : y;
        r = sb ? x - y : x + y + longint'(ci);
        e = sb ? sx - sy : sx + sy + longint'(ci);
        s = r & m;
        co = sb ? (x >= y) : (r > m);
        ov = (e >= half) || (e < -half);
        z = s == 0;
    endfunction

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts, input logic tc, output int lat);
        a = ta; b = tb; sub = ts; cin = tc; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0; a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
        lat = 41;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = i; break; end
        end
    endtask

    task automatic finish_op;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic test_reset;
        rst = 1; in_valid = 1; a = 32'h11; b = 32'h22;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (sum !== 0) begin errors++; $display("FAIL reset_sum: got %h want 0", sum); end
        checks++;
        if ({cout, ovf, zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {cout, ovf, zero}); end
        rst = 0; in_valid = 0;
        checks++;
        if (in_ready !== 1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1 || out_valid !== 0) begin
            errors++; $display("FAIL reset_no_accept: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_latency_carry;
        int lat;
        do_op(32'hFFFFFFFF, 32'h1, 0, 0, lat);
        checks++;
        if (lat !== 8 || sum !== 32'h0 || {cout, ovf, zero} !== 3'b101) begin
            errors++; $display("FAIL carry_wrap: lat=%0d sum=%h c/o/z=%b want 8 00000000 101", lat, sum, {cout, ovf, zero});
        end
        finish_op;
        checks++;
        if (out_valid !== 0 || in_ready !== 1) begin
            errors++; $display("FAIL release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        do_op(32'h1, 32'h1, 0, 1, lat);
        checks++;
        if (lat !== 8 || sum !== 32'h3 || {cout, ovf, zero} !== 3'b000) begin
            errors++; $display("FAIL add_cin: lat=%0d sum=%h c/o/z=%b want 8 00000003 000", lat, sum, {cout, ovf, zero});
        end
        finish_op;
    endtask

    task automatic test_overflow;
        int lat;
        do_op(32'h7FFFFFFF, 32'h1, 0, 0, lat);
        checks++;
        if (lat !== 8 || sum !== 32'h80000000 || {cout, ovf, zero} !== 3'b010) begin
            errors++; $display("FAIL add_ovf: lat=%0d sum=%h c/o/z=%b want 8 80000000 010", lat, sum, {cout, ovf, zero});
        end
        finish_op;
        do_op(32'h5, 32'h7, 1, 1, lat);
        checks++;
        if (lat !== 8 || sum !== 32'hFFFFFFFE || {cout, ovf, zero} !== 3'b000) begin
            errors++; $display("FAIL sub_borrow: lat=%0d sum=%h c/o/z=%b want 8 fffffffe 000", lat, sum, {cout, ovf, zero});
        end
        finish_op;
        do_op(32'h80000000, 32'h1, 1, 0, lat);
        checks++;
        if (lat !== 8 || sum !== 32'h7FFFFFFF || {cout, ovf, zero} !== 3'b110) begin
            errors++; $display("FAIL sub_ovf: lat=%0d sum=%h c/o/z=%b want 8 7fffffff 110", lat, sum, {cout, ovf, zero});
        end
        finish_op;
    endtask

    task automatic test_back_pressure;
        int lat;
        do_op(32'h2, 32'h3, 0, 0, lat);
        checks++;
        if (lat !== 8 || sum !== 32'h5) begin errors++; $display("FAIL bp_first: lat=%0d sum=%h want 8 00000005", lat, sum); end
        a = 32'd10; b = 32'd20; sub = 0; cin = 0; in_valid = 1; out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1 || in_ready !== 0 || sum !== 32'h5 || {cout, ovf, zero} !== 3'b000) begin
                errors++; $display("FAIL bp_hold%0d: ov=%b ir=%b sum=%h flags=%b want 1 0 00000005 000", i, out_valid, in_ready, sum, {cout, ovf, zero});
            end
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        checks++;
        if (out_valid !== 0 || in_ready !== 1 || sum !== 32'h5) begin
            errors++; $display("FAIL bp_release: ov=%b ir=%b sum=%h want 0 1 00000005", out_valid, in_ready, sum);
        end
        @(posedge clk); #1;
        in_valid = 0;
        checks++;
        if (in_ready !== 0) begin errors++; $display("FAIL bp_accept: in_ready=%b want 0", in_ready); end
        lat = 41;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = i; break; end
        end
        checks++;
        if (lat !== 8 || sum !== 32'h1E) begin errors++; $display("FAIL bp_second: lat=%0d sum=%h want 8 0000001e", lat, sum); end
        finish_op;
    endtask

    task automatic test_mid_reset;
        int lat;
        bit seen;
        a = 32'hDEADBEEF; b = 32'h01234567; sub = 0; cin = 0; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        checks++;
        if (seen !== 0 || in_ready !== 1) begin
            errors++; $display("FAIL mid_reset_abort: seen_valid=%b in_ready=%b want 0 1", seen, in_ready);
        end
        do_op(32'h12345678, 32'h11111111, 0, 0, lat);
        checks++;
        if (lat !== 8 || sum !== 32'h23456789 || {cout, ovf, zero} !== 3'b000) begin
            errors++; $display("FAIL mid_reset_next: lat=%0d sum=%h flags=%b want 8 23456789 000", lat, sum, {cout, ovf, zero});
        end
        finish_op;
    endtask

    task automatic test_sweep4;
        longint es;
        bit ec, eo, ez;
        int l41, l44;
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int sb = 0; sb < 2; sb++)
                    for (int ci = 0; ci < 2; ci++) begin
                        a4 = 4'(x); b4 = 4'(y); s4 = sb[0]; c4 = ci[0]; v4 = 1;
                        @(posedge clk); #1;
                        v4 = 0; a4 = ~a4; b4 = ~b4; s4 = ~s4;
                        l41 = 0; l44 = 0;
                        for (int i = 1; i <= 10; i++) begin
                            @(posedge clk); #1;
                            if (ov41 && l41 == 0) l41 = i;
                            if (ov44 && l44 == 0) l44 = i;
                            if (l41 != 0 && l44 != 0) break;
                        end
                        model(4, longint'(x), longint'(y), sb[0], ci[0], es, ec, eo, ez);
                        checks++;
                        if (l41 !== 4 || sm41 !== es[3:0] || {co41, of41, z41} !== {ec, eo, ez}) begin
                            errors++; $display("FAIL sweep41 a=%h b=%h sub=%0d cin=%0d: lat=%0d sum=%h c/o/z=%b want 4 %h %b",
                                x, y, sb, ci, l41, sm41, {co41, of41, z41}, es[3:0], {ec, eo, ez});
                        end
                        checks++;
                        if (l44 !== 1 || sm44 !== es[3:0] || {co44, of44, z44} !== {ec, eo, ez}) begin
                            errors++; $display("FAIL sweep44 a=%h b=%h sub=%0d cin=%0d: lat=%0d sum=%h c/o/z=%b want 1 %h %b",
                                x, y, sb, ci, l44, sm44, {co44, of44, z44}, es[3:0], {ec, eo, ez});
                        end
                        r4 = 1;
                        @(posedge clk); #1;
                        r4 = 0;
                    end
    endtask

    task automatic test_random32;
        longint es;
        bit ec, eo, ez;
        logic [31:0] ra, rb;
        logic rs, rc;
        int lat;
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom); rc = 1'($urandom);
            a8 = ra; b8 = rb; s8 = rs; c8 = rc; v8 = 1;
            @(posedge clk); #1;
            v8 = 0; a8 = ~ra; b8 = ~rb; s8 = ~rs;
            lat = 11;
            for (int i = 1; i <= 10; i++) begin
                @(posedge clk); #1;
                if (ov8) begin lat = i; break; end
            end
            model(32, {32'h0, ra}, {32'h0, rb}, rs, rc, es, ec, eo, ez);
            checks++;
            if (lat !== 4 || sm8 !== es[31:0] || {co8, of8, z8} !== {ec, eo, ez}) begin
                errors++; $display("FAIL rand32 a=%h b=%h sub=%b cin=%b: lat=%0d sum=%h c/o/z=%b want 4 %h %b",
                    ra, rb, rs, rc, lat, sm8, {co8, of8, z8}, es[31:0], {ec, eo, ez});
            end
            r8 = 1;
            @(posedge clk); #1;
            r8 = 0;
        end
    endtask

    initial begin
        test_reset;
        test_latency_carry;
        test_overflow;
        test_back_pressure;
        test_mid_reset;
        test_sweep4;
        test_random32;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
